// File: rtl/frogger_pkg.sv
// Shared Frogger types: move directions, arrow keycodes and repeat-FSM states.
// Also holds the arrow decode used by the input controller.
package frogger_pkg;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_e;

  localparam logic [15:0] KC_UP    = 16'h0052;
  localparam logic [15:0] KC_DOWN  = 16'h0051;
  localparam logic [15:0] KC_LEFT  = 16'h0050;
  localparam logic [15:0] KC_RIGHT = 16'h004F;

  typedef struct packed {
    logic valid;
    dir_e dir;
  } arrow_t;

  function automatic arrow_t decode_arrow(input logic [15:0] kc);
    arrow_t a;
    a.valid = 1'b1;
    a.dir   = DIR_UP;
    case (kc)
      KC_UP:    a.dir = DIR_UP;
      KC_DOWN:  a.dir = DIR_DOWN;
      KC_LEFT:  a.dir = DIR_LEFT;
      KC_RIGHT: a.dir = DIR_RIGHT;
      default:  a.valid = 1'b0;
    endcase
    return a;
  endfunction

  function automatic logic [3:0] dir_onehot(input dir_e d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings an asynchronous level (e.g. VGA vsync) into the Clk domain and
// emits a one-cycle registered tick on each rising edge.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic async_in,
  output logic tick
);

  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync <= '0;
      prev <= 1'b0;
      tick <= 1'b0;
    end else begin
      // NOTE: non-blocking so each stage samples its neighbour's pre-edge value.
      sync <= {sync[0], async_in};
      prev <= sync[1];
      tick <= sync[1] & ~prev;
    end
  end

endmodule

// File: rtl/frog_input_ctrl.sv
// Keyboard-to-frog control: sticky frog selection plus frame-synchronised
// arrow moves with delay/rate auto-repeat and a game-over freeze.
module frog_input_ctrl
  import frogger_pkg::*;
#(
  parameter int          NUM_FROGS    = 3,
  parameter logic [15:0] SEL_KEY_BASE = 16'h0059,
  parameter int          REPEAT_DELAY = 20,
  parameter int          REPEAT_RATE  = 6
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [15:0]          keycode,
  input  logic                 frame_clk,
  input  logic                 freeze,
  output logic [NUM_FROGS-1:0] active_onehot,
  output logic [2:0]           active_idx,
  output logic                 active_valid,
  output logic                 move_strobe,
  output logic [1:0]           move_dir,
  output logic [3:0]           move_level
);

  if (NUM_FROGS < 1 || NUM_FROGS > 8 || REPEAT_DELAY < 1 || REPEAT_DELAY > 63 ||
      REPEAT_RATE < 1 || REPEAT_RATE > 63) begin : g_bad_params
    $error("frog_input_ctrl: parameter out of range");
  end

  localparam logic [5:0] DELAY_LOAD = 6'(REPEAT_DELAY - 1);
  localparam logic [5:0] RATE_LOAD  = 6'(REPEAT_RATE - 1);

  logic frame_tick;

  frame_tick_sync u_frame_sync (
    .Clk      (Clk),
    .Reset    (Reset),
    .async_in (frame_clk),
    .tick     (frame_tick)
  );

  arrow_t arrow;
  assign arrow = decode_arrow(keycode);

  // Offset wraps for keycodes below the base, so one unsigned compare covers both bounds.
  logic [15:0] sel_offset;
  logic        sel_hit;
  logic [2:0]  sel_idx;
  logic        sel_change;

  assign sel_offset = keycode - SEL_KEY_BASE;
  assign sel_hit    = sel_offset < 16'(NUM_FROGS);
  assign sel_idx    = sel_offset[2:0];
  assign sel_change = sel_hit && (!active_valid || sel_idx != active_idx);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      active_onehot <= '0;
      active_idx    <= '0;
      active_valid  <= 1'b0;
    end else if (sel_change) begin
      active_onehot <= NUM_FROGS'(1) << sel_idx;
      active_idx    <= sel_idx;
      active_valid  <= 1'b1;
    end
  end

  state_e     state, state_n;
  logic [5:0] cnt, cnt_n;
  logic       emit;
  dir_e       dir_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_n = state;
    cnt_n   = cnt;
    emit    = 1'b0;
    if (sel_change || freeze || !active_valid) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (frame_tick) begin
      unique case (state)
        IDLE: begin
          if (arrow.valid) begin
            emit    = 1'b1;
            cnt_n   = DELAY_LOAD;
            state_n = DELAY;
          end
        end
        DELAY, REPEAT: begin
          if (!arrow.valid) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (arrow.dir != dir_q) begin
            emit    = 1'b1;
            cnt_n   = DELAY_LOAD;
            state_n = DELAY;
          end else if (cnt == '0) begin
            emit    = 1'b1;
            cnt_n   = RATE_LOAD;
            state_n = REPEAT;
          end else begin
            cnt_n = cnt - 6'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      move_strobe <= 1'b0;
      dir_q       <= DIR_UP;
      move_level  <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      move_strobe <= emit;
      if (emit) begin
        dir_q      <= arrow.dir;
        move_level <= dir_onehot(arrow.dir);
      end else if (frame_tick) begin
        move_level <= '0;
      end
    end
  end

  assign move_dir = dir_q;

endmodule

// File: tb/tb_frog_input_ctrl.sv
// Frame-by-frame bench: directed key sequences then random keycodes/freeze,
// compared against a hold-time model of selection and auto-repeat.
module tb_frog_input_ctrl;

  localparam int          NUM_FROGS    = 3;
  localparam logic [15:0] SEL_KEY_BASE = 16'h0059;
  localparam int          REPEAT_DELAY = 20;
  localparam int          REPEAT_RATE  = 6;

  logic                 Clk = 1'b0;
  logic                 Reset;
  logic [15:0]          keycode;
  logic                 frame_clk;
  logic                 freeze;
  logic [NUM_FROGS-1:0] active_onehot;
  logic [2:0]           active_idx;
  logic                 active_valid;
  logic                 move_strobe;
  logic [1:0]           move_dir;
  logic [3:0]           move_level;

  frog_input_ctrl #(
    .NUM_FROGS    (NUM_FROGS),
    .SEL_KEY_BASE (SEL_KEY_BASE),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .frame_clk     (frame_clk),
    .freeze        (freeze),
    .active_onehot (active_onehot),
    .active_idx    (active_idx),
    .active_valid  (active_valid),
    .move_strobe   (move_strobe),
    .move_dir      (move_dir),
    .move_level    (move_level)
  );

  always #10 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: selected frog (-1 none), arrow currently being held as a run (-1 none),
  // frames since that run's first move, and the level the last frame left behind.
  int         m_sel   = -1;
  int         m_run   = -1;
  int         m_h     = 0;
  logic [3:0] m_level = 4'b0;

  function automatic int arrow_of(input logic [15:0] kc);
    case (kc)
      16'h0052: return 0;
      16'h0051: return 1;
      16'h0050: return 2;
      16'h004F: return 3;
      default:  return -1;
    endcase
  endfunction

  function automatic int sel_of(input logic [15:0] kc);
    if (kc >= SEL_KEY_BASE && int'(kc) < int'(SEL_KEY_BASE) + NUM_FROGS)
      return int'(kc - SEL_KEY_BASE);
    return -1;
  endfunction

  task automatic model_frame(input logic [15:0] kc, input logic frz,
                             output bit emit, output int dir);
    int s;
    int a;
    s    = sel_of(kc);
    a    = arrow_of(kc);
    emit = 1'b0;
    dir  = a;
    if (s >= 0 && s != m_sel) begin
      m_sel = s;
      m_run = -1;
    end
    if (frz || m_sel < 0 || a < 0) begin
      m_run = -1;
    end else if (m_run != a) begin
      m_run = a;
      m_h   = 0;
      emit  = 1'b1;
    end else begin
      m_h++;
      emit = (m_h >= REPEAT_DELAY) && ((m_h - REPEAT_DELAY) % REPEAT_RATE == 0);
    end
  endtask

  task automatic check_selection(input string tag);
    logic [NUM_FROGS-1:0] exp_oh;
    exp_oh = (m_sel < 0) ? '0 : NUM_FROGS'(1) << m_sel;
    check({tag, "_onehot"}, 32'(active_onehot), 32'(exp_oh));
    check({tag, "_idx"},    32'(active_idx),    (m_sel < 0) ? 32'd0 : 32'(m_sel));
    check({tag, "_valid"},  32'(active_valid),  32'(m_sel >= 0));
  endtask

  // One frame: keycode/freeze held for the whole window, one frame_clk pulse.
  // sel_pulse swaps in the frog-2 key around the tick, then restores kc.
  task automatic run_frame(input logic [15:0] kc, input logic frz, input bit sel_pulse = 1'b0);
    bit         emit;
    int         dir;
    int         strobes;
    logic [1:0] seen_dir;
    strobes  = 0;
    seen_dir = 2'd0;
    @(negedge Clk);
    keycode = kc;
    freeze  = frz;
    repeat (2) @(negedge Clk);
    check("level_held", 32'(move_level), 32'(m_level));
    frame_clk = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (sel_pulse) keycode = (i < 5) ? 16'h005B : kc;
      if (i == 7) frame_clk = 1'b0;
      @(negedge Clk);
      if (move_strobe) begin
        strobes++;
        seen_dir = move_dir;
      end
    end
    model_frame(sel_pulse ? 16'h005B : kc, frz, emit, dir);
    check("strobe_count", 32'(strobes), 32'(emit));
    if (emit) check("move_dir", 32'(seen_dir), 32'(dir));
    m_level = emit ? (4'b0001 << dir) : 4'b0000;
    check("move_level", 32'(move_level), 32'(m_level));
    check_selection("sel");
  endtask

  logic [15:0] pool [10] = '{16'h0000, 16'h0052, 16'h0051, 16'h0050, 16'h004F,
                             16'h0059, 16'h005A, 16'h005B, 16'h005C, 16'h1234};

  initial begin
    logic [15:0] kc;
    logic        frz;
    Reset     = 1'b1;
    keycode   = 16'h0000;
    frame_clk = 1'b0;
    freeze    = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("rst_strobe", 32'(move_strobe), 32'd0);
    check("rst_dir",    32'(move_dir),    32'd0);
    check("rst_level",  32'(move_level),  32'd0);
    check_selection("rst");

    // Selection loads one Clk after the key appears.
    keycode = 16'h005A;
    @(negedge Clk);
    m_sel = sel_of(16'h005A);
    check_selection("sel_1clk");
    run_frame(16'h0000, 1'b0);
    run_frame(16'h005C, 1'b0);
    run_frame(16'h0059, 1'b0);

    run_frame(16'h0052, 1'b0);
    run_frame(16'h0000, 1'b0);
    run_frame(16'h0000, 1'b0);

    repeat (40) run_frame(16'h004F, 1'b0);
    run_frame(16'h0000, 1'b0);

    repeat (5)  run_frame(16'h0050, 1'b0);
    repeat (25) run_frame(16'h0051, 1'b0);
    run_frame(16'h0000, 1'b0);

    repeat (10) run_frame(16'h0052, 1'b1);
    repeat (2)  run_frame(16'h0052, 1'b0);

    run_frame(16'h0052, 1'b0, 1'b1);
    run_frame(16'h0052, 1'b0);

    // Hold right deep into auto-repeat, then reset asynchronously.
    repeat (30) run_frame(16'h004F, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("async_rst_strobe", 32'(move_strobe),   32'd0);
    check("async_rst_dir",    32'(move_dir),      32'd0);
    check("async_rst_level",  32'(move_level),    32'd0);
    check("async_rst_onehot", 32'(active_onehot), 32'd0);
    check("async_rst_idx",    32'(active_idx),    32'd0);
    check("async_rst_valid",  32'(active_valid),  32'd0);
    @(negedge Clk);
    Reset   = 1'b0;
    m_sel   = -1;
    m_run   = -1;
    m_level = 4'b0;
    repeat (2) run_frame(16'h004F, 1'b0);
    run_frame(16'h0059, 1'b0);

    kc  = 16'h004F;
    frz = 1'b0;
    for (int f = 0; f < 200; f++) begin
      if ($urandom_range(9) == 0) kc = pool[$urandom_range(9)];
      if ($urandom_range(11) == 0) frz = ~frz;
      run_frame(kc, frz);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
